// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ requesters.
// Grants a requester, launches the transmitter, then follows tx_busy until the frame ends.
module uart_tx_sched #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      active_id,
  output logic                 idle,
  output logic                 err_timeout,
  output logic [15:0]          sent_cnt
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              idle_q, idle_d;
  logic              err_q, err_d;
  logic [15:0]       sent_cnt_q, sent_cnt_d;

  logic              hi_found, lo_found, win_found;
  logic [ID_W-1:0]   hi_id, lo_id, win_id;
  logic [7:0]        hi_byte, lo_byte, win_byte;
  logic              arb_go, to_last;

  // Rotating priority: prefer the lowest requester above last_gnt, else wrap to the lowest overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi_found = 1'b0;
    hi_id    = '0;
    hi_byte  = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    lo_byte  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hi_found && req[i] && (i > int'(last_gnt_q))) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(i);
        hi_byte  = req_data[8*i +: 8];
      end
      if (!lo_found && req[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        lo_byte  = req_data[8*i +: 8];
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id   : lo_id;
    win_byte  = hi_found ? hi_byte : lo_byte;
  end

  assign arb_go  = win_found && !tx_busy;
  assign to_last = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      active_id_q <= '0;
      last_gnt_q  <= ID_W'(N_REQ - 1);
      to_cnt_q    <= '0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      sent_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      active_id_q <= active_id_d;
      last_gnt_q  <= last_gnt_d;
      to_cnt_q    <= to_cnt_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  // tx_busy takes precedence over an expiring timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (arb_go) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_DONE;
                   else if (to_last) state_d = S_IDLE;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    active_id_d = active_id_q;
    last_gnt_d  = last_gnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    sent_cnt_d  = sent_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_go) begin
          gnt_d       = N_REQ'(1) << win_id;
          tx_start_d  = 1'b1;
          tx_data_d   = win_byte;
          active_id_d = win_id;
          last_gnt_d  = win_id;
          to_cnt_d    = '0;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_busy) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_last) err_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) sent_cnt_d = sent_cnt_q + 16'd1;
      end
      default: ;
    endcase
    idle_d = (state_d == S_IDLE);
  end

  assign gnt         = gnt_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign active_id   = active_id_q;
  assign idle        = idle_q;
  assign err_timeout = err_q;
  assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: arbitration order, blocking on tx_busy, timeout,
// mid-frame reset and frame-counter wrap, with hand-computed expectations.
module tb_uart_tx_sched;

  localparam int TO_CYC = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  active_id;
  logic        idle;
  logic        err_timeout;
  logic [15:0] sent_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int gnt_pulses = 0;
  int start_pulses = 0;
  int shape_errs = 0;
  int g0, s0;
  logic [3:0] gnt_prev = '0;
  logic       model_en = 1'b0;

  uart_tx_sched #(.N_REQ(4), .ID_W(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active_id(active_id),
    .idle(idle), .err_timeout(err_timeout), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse shape monitor: gnt must be one-hot, one cycle, and coincide with tx_start.
  always @(negedge clk) begin
    if (|gnt) gnt_pulses++;
    if (tx_start) start_pulses++;
    if (((|gnt) != tx_start) || ((|gnt) && (|gnt_prev)) || ($countones(gnt) > 1)) shape_errs++;
    gnt_prev = gnt;
  end

  // Transmitter model: busy rises 2 cycles after the launch and stays high for 20 cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (model_en && tx_start === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_gnt(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (idle === 1'b1) seen = 1'b1;
    end
    check({tag, "_idle"}, 32'(seen), 32'd1);
  endtask

  task automatic do_frame(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_data,
                          input logic [1:0] exp_id, input logic drop);
    wait_gnt(tag);
    check({tag, "_gnt"}, gnt, exp_gnt);
    check({tag, "_start"}, tx_start, 1'b1);
    check({tag, "_data"}, tx_data, exp_data);
    check({tag, "_id"}, active_id, exp_id);
    check({tag, "_busy_idle"}, idle, 1'b0);
    if (drop) req = 4'b0000;
    @(negedge clk);
    check({tag, "_gnt_off"}, gnt, 4'b0000);
    check({tag, "_start_off"}, tx_start, 1'b0);
    check({tag, "_data_hold"}, tx_data, exp_data);
    wait_idle(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, gnt, 4'b0000);
    check({tag, "_start"}, tx_start, 1'b0);
    check({tag, "_data"}, tx_data, 8'h00);
    check({tag, "_id"}, active_id, 2'd0);
    check({tag, "_idle"}, idle, 1'b1);
    check({tag, "_err"}, err_timeout, 1'b0);
    check({tag, "_sent"}, sent_cnt, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Single requester, single frame.
    model_en = 1'b1;
    req_data[7:0] = 8'h5A;
    g0 = gnt_pulses; s0 = start_pulses;
    req = 4'b0001;
    do_frame("t1", 4'b0001, 8'h5A, 2'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_gnt_count", gnt_pulses - g0, 1);
    check("t1_start_count", start_pulses - s0, 1);
    check("t1_sent", sent_cnt, 16'd1);
    check("t1_idle", idle, 1'b1);

    // All requesters held high: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    req_data = 32'h4443_4241;
    req = 4'b1111;
    for (int i = 0; i < 8; i++)
      do_frame($sformatf("t2_f%0d", i), 4'b0001 << (i % 4), 8'h41 + 8'(i % 4), 2'(i % 4), i == 7);
    check("t2_sent", sent_cnt, 16'd8);

    // Request while tx_busy high in IDLE is held off until busy is sampled low.
    model_en = 1'b0;
    tx_busy = 1'b1;
    req = 4'b0100;
    g0 = gnt_pulses;
    repeat (5) @(negedge clk);
    check("t3_blocked", gnt_pulses - g0, 0);
    check("t3_idle", idle, 1'b1);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t3_gnt", gnt, 4'b0100);
    check("t3_data", tx_data, 8'h43);
    req = 4'b0000;
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    wait_idle("t3");
    check("t3_sent", sent_cnt, 16'd9);

    // Transmitter never answers: timeout after exactly TO_CYC cycles in WAIT_BUSY.
    req = 4'b0010;
    wait_gnt("t4");
    check("t4_gnt", gnt, 4'b0010);
    req = 4'b0000;
    repeat (TO_CYC - 1) @(negedge clk);
    check("t4_err_early", err_timeout, 1'b0);
    check("t4_idle_early", idle, 1'b0);
    @(negedge clk);
    check("t4_err", err_timeout, 1'b1);
    check("t4_idle", idle, 1'b1);
    check("t4_sent", sent_cnt, 16'd9);
    model_en = 1'b1;
    req = 4'b0001;
    do_frame("t4_next", 4'b0001, 8'h41, 2'd0, 1'b1);
    check("t4_next_sent", sent_cnt, 16'd10);
    check("t4_err_sticky", err_timeout, 1'b1);

    // Reset during WAIT_DONE with tx_busy still high and requester 0 pending.
    model_en = 1'b0;
    req = 4'b0100;
    wait_gnt("t5");
    check("t5_gnt", gnt, 4'b0100);
    req = 4'b0001;
    tx_busy = 1'b1;
    @(negedge clk);
    check("t5_in_done", idle, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("t5_rst");
    rst_n = 1'b1;
    g0 = gnt_pulses;
    repeat (4) @(negedge clk);
    check("t5_blocked", gnt_pulses - g0, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t5_gnt_after", gnt, 4'b0001);
    check("t5_data_after", tx_data, 8'h41);
    req = 4'b0000;
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    wait_idle("t5");
    check("t5_sent", sent_cnt, 16'd1);

    // tx_busy rises on the very edge the timeout would expire: busy wins.
    req = 4'b0010;
    wait_gnt("t6");
    check("t6_gnt", gnt, 4'b0010);
    req = 4'b0000;
    repeat (TO_CYC - 1) @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    check("t6_err", err_timeout, 1'b0);
    check("t6_in_done", idle, 1'b0);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t6_idle", idle, 1'b1);
    check("t6_sent", sent_cnt, 16'd2);

    // Frame counter wrap.
    force dut.sent_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_cnt_q;
    @(negedge clk);
    check("t7_preload", sent_cnt, 16'hFFFF);
    model_en = 1'b1;
    req = 4'b0001;
    do_frame("t7", 4'b0001, 8'h41, 2'd0, 1'b1);
    check("t7_wrap", sent_cnt, 16'h0000);

    repeat (2) @(negedge clk);
    check("pulse_shape", shape_errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
